// File: rtl/kw_reset_sequencer.sv
// kw_reset_sequencer
//
// Purpose:
//   Multi-domain startup reset controller. It stretches power-on reset and
//   software reset requests into a minimum-width assertion of every domain.
//   It then releases the domains one at a time, lowest index first, with a
//   fixed gap between releases. It sits upstream of the per-domain reset
//   synchronizers.
//
// Parameters:
//   DOMAINS      number of sequenced reset outputs (>=1); bit 0 is released first
//   HOLD_CYCLES  edges every output stays asserted before domain 0 is released
//   GAP_CYCLES   edges between release of domain k-1 and domain k
//
// Ports:
//   clock      in   sequencer clock
//   i_reset_n  in   asynchronous active-low reset (deassertion synchronous to clock)
//   testmode   in   scan bypass: every o_reset_n bit follows i_reset_n directly
//   i_req      in   software reset request (level, 4-phase with o_ack)
//   o_ack      out  request sequence complete (registered)
//   o_reset_n  out  sequenced active-low resets (registered unless testmode)
//   o_done     out  all domains released (registered)
//
// Request handshake (4-phase, level based):
//   The requester raises i_req and holds it. The sequencer accepts the request
//   in RUN when it samples i_req=1 with o_ack=0. It runs a full hold/release
//   sequence and raises o_ack on the final release edge, but only if i_req is
//   still high on that edge. The requester then drops i_req, and o_ack falls
//   on the first edge that samples i_req=0. A high i_req never retriggers
//   while o_ack=1.
//
//   If i_req drops while a sequence is in flight, the handshake is abandoned.
//   The sequence still completes, but no ack is raised. Changes on i_req
//   during HOLD/RELEASE never shorten or restart a sequence.
//
// Internal state:
//   state_q is the FSM state (HOLD / RELEASE / RUN). It is kept as a named
//   register so that checkers can bind to it.

module kw_reset_sequencer #(
  parameter int DOMAINS     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic               testmode,
  input  logic               i_req,
  output logic               o_ack,
  output logic [DOMAINS-1:0] o_reset_n,
  output logic               o_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(DOMAINS + 1);

  // The counter holds the number of edges already counted in this phase.
  // The phase ends on the edge where that number would reach its target.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               by_req_q, by_req_d;
  logic [DOMAINS-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;

  logic hold_end;
  logic gap_end;
  logic last_dom;
  logic req_accept;

  assign hold_end   = (cnt_q == HOLD_LAST);
  assign gap_end    = (cnt_q == GAP_LAST);
  assign last_dom   = (idx_q == LAST_IDX);
  // A request is honoured only once the previous ack has been withdrawn.
  assign req_accept = i_req & ~ack_q;

  // --------------------------------------------------------------------------
  // State register (all sequencer state, asynchronous active-low reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      by_req_q <= 1'b0;
      rst_q    <= '0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      by_req_q <= by_req_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: FSM state, shared counter, domain index, by_req flag
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    by_req_d = by_req_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_end) begin
          cnt_d = '0;
          if (DOMAINS == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (gap_end) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (last_dom) begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (req_accept) begin
          // The accepting edge is edge 0 of the new hold count.
          state_d  = ST_HOLD;
          cnt_d    = '0;
          idx_d    = '0;
          by_req_d = 1'b1;
        end else if (!i_req) begin
          by_req_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_HOLD;
        cnt_d    = '0;
        idx_d    = '0;
        by_req_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values of the registered resets, done and ack
  // --------------------------------------------------------------------------
  always_comb begin
    rst_d  = rst_q;
    done_d = done_q;
    ack_d  = ack_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_end) begin
          rst_d[0] = 1'b1;
          // With a single domain the hold edge is also the final release.
          // The ack rule of the final release therefore applies here too.
          if (DOMAINS == 1) begin
            done_d = 1'b1;
            ack_d  = by_req_q & i_req;
          end
        end
      end

      ST_RELEASE: begin
        if (gap_end) begin
          // Bits only ever rise, and only in index order.
          for (int i = 0; i < DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              rst_d[i] = 1'b1;
            end
          end
          if (last_dom) begin
            done_d = 1'b1;
            ack_d  = by_req_q & i_req;
          end
        end
      end

      ST_RUN: begin
        if (req_accept) begin
          rst_d  = '0;
          done_d = 1'b0;
        end else if (!i_req) begin
          ack_d = 1'b0;
        end
      end

      default: begin
        rst_d  = '0;
        done_d = 1'b0;
        ack_d  = 1'b0;
      end
    endcase
  end

  // Test bypass touches only the reset outputs; the sequencer keeps running.
  assign o_reset_n = testmode ? {DOMAINS{i_reset_n}} : rst_q;
  assign o_done    = done_q;
  assign o_ack     = ack_q;

endmodule

// File: doc/kw_reset_sequencer.md
# kw_reset_sequencer

Reset controller for multi-domain startup: stretches the power-on reset and software reset requests into a minimum-width assertion, then releases a set of ordered reset domains one at a time with a fixed gap between them. It sits upstream of the per-domain reset synchronizers. It drives ordered active-low resets to each subsystem and answers a 4-phase reset request/acknowledge handshake from a controller or debug agent.

## Interface
- DOMAINS, 3, number of sequenced reset outputs (≥1); bit 0 is released first.
- HOLD_CYCLES, 16, clock edges all outputs stay asserted before domain 0 is released (≥1).
- GAP_CYCLES, 4, clock edges between release of domain k-1 and domain k (≥1).
- clock  input  1  sequencer clock.
- i_reset_n  input  1  asynchronous, active-low reset.
  - Deassertion is synchronous to clock, driven by an AASD reset synchronizer in this domain.
- testmode  input  1  scan/test bypass.
  - When 1, every o_reset_n bit equals i_reset_n combinationally.
- i_req  input  1  software reset request.
  - Level signal, synchronous to clock, 4-phase with o_ack.
- o_ack  output  1  request-sequence complete; registered.
- o_reset_n  output  DOMAINS  sequenced active-low resets; registered (except in testmode).
- o_done  output  1  all domains released; registered.

## Operation
- FSM states: HOLD, RELEASE, RUN. A single counter of width $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1) is shared by both timed states. A domain index of width $clog2(DOMAINS+1) tracks release progress.
- Flag `by_req` records whether the current sequence was started by i_req.
- Async reset (i_reset_n=0), from any state:
  - state=HOLD, counter=0, index=0, by_req=0.
  - o_reset_n=all 0, o_done=0, o_ack=0; all take effect immediately, without a clock edge.
- HOLD:
  - Counter increments each edge.
  - On the edge where the count reaches HOLD_CYCLES: set o_reset_n[0]=1 and clear the counter.
  - Go to RUN if DOMAINS=1 (also setting o_done); otherwise go to RELEASE with index=1.
- RELEASE:
  - Counter increments each edge.
  - On the edge where the count reaches GAP_CYCLES: set o_reset_n[index]=1, clear the counter, increment index.
  - When the last domain is released on that edge: set o_done=1, go to RUN, and set o_ack=1 iff by_req=1 and i_req=1 on that edge.
- RUN, on an edge sampling i_req=1 and o_ack=0:
  - Clear o_reset_n to all 0, clear o_done, set by_req=1.
  - Go to HOLD with counter=0; this edge is edge 0 of the hold count.
- RUN, on an edge sampling i_req=0: clear o_ack and by_req.
- i_req=1 while o_ack=1 never retriggers; the requester must drop i_req and observe o_ack=0 first.
- i_req changes during HOLD/RELEASE are ignored; the sequence always runs to completion.
  - If i_req is low when the last domain is released, o_ack stays 0 (aborted handshake; no ack is owed).
- o_reset_n bits only ever rise in index order and all fall together. No bit falls individually.
- testmode affects o_reset_n only. The FSM, o_done and o_ack keep running normally.

## Timing
- Power-on, with edge 1 the first rising edge after i_reset_n deasserts:
  - o_reset_n[0] rises after edge HOLD_CYCLES.
  - o_reset_n[k] rises after edge HOLD_CYCLES + k·GAP_CYCLES.
  - o_done rises on the same edge as o_reset_n[DOMAINS-1].
- Request sampled at edge T:
  - o_reset_n falls to all 0 after T.
  - o_reset_n[k] rises after T + HOLD_CYCLES + k·GAP_CYCLES.
  - o_ack rises on the final release edge.
- o_ack falls one edge after i_req is sampled 0, i.e. on the first edge sampling i_req=0.
- Minimum spacing from request to next accepted request: ack-low cycle plus one edge.
- i_reset_n assertion mid-sequence aborts it asynchronously. Release then restarts from the power-on timing.

## Test plan
- POR, DOMAINS=3, HOLD=16, GAP=4, testmode=0, i_req=0 → o_reset_n goes 000 → 001 after edge 16 → 011 after edge 20 → 111 after edge 24; o_done=1 after edge 24; o_ack stays 0.
- After POR, i_req=1 sampled at edge T=40, held high → o_reset_n=000 and o_done=0 after edge 40; releases after edges 56, 60, 64; o_ack=1 after edge 64. Drop i_req before edge 70 → o_ack=0 after edge 70.
- Keep i_req=1 for 20 edges past ack → no new sequence, o_reset_n stays 111. Drop i_req, then raise it again → a second full sequence runs.
- i_req=1 at edge T then low at T+5 → full sequence still completes (111 after T+24), o_ack never rises.
- Pull i_reset_n low at POR edge 18 (o_reset_n=001) → o_reset_n=000 immediately without a clock edge. After release, same 16/20/24 schedule.
- testmode=1 → o_reset_n tracks i_reset_n combinationally (all 0/all 1). Set testmode=0 mid-hold → the registered sequence values appear.
